mdu_seq: RTL and testbench

//  Multi-cycle multiply/divide unit; sequential companion to the single-cycle ALU in the execute stage.
//  The datapath issues an operation with Start; the MDU responds by holding Busy for a fixed latency
//  and then writing HI/LO. The datapath stalls on Busy and reads HI/LO for mfhi/mflo.

---
 rtl/mdu_seq_if.sv | 13 +
 rtl/mdu_seq.sv | 130 +++++++++++++
 tb/tb_mdu_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Issue/result bundle between the execute-stage datapath (master) and the MDU (slave).
interface mdu_seq_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, SrcA, SrcB, input Busy, HI, LO);
  modport slave  (input Start, MDUOp, SrcA, SrcB, output Busy, HI, LO);
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit: fixed-latency mult/div writing HI/LO, zero-latency mthi/mtlo.
// Define MDU_MADD_EN to enable op 110 (madd, HI:LO accumulate); otherwise op 110 is a no-op.
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_seq_if.slave  mdu
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  function automatic logic is_long_op(input logic [2:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD);
`endif
    return r;
  endfunction

  // Result datapath works only on the operands latched at accept.
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_bs, div_bu;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign b_zero = (b_q == 32'd0);
  assign abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign abs_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign div_bs = b_zero ? 32'd1 : abs_b;
  assign div_bu = b_zero ? 32'd1 : b_q;
  assign q_mag  = abs_a / div_bs;
  assign r_mag  = abs_a % div_bs;
  assign q_s    = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = a_q[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u    = a_q / div_bu;
  assign r_u    = a_q % div_bu;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (mdu.Start) begin
          if (is_long_op(mdu.MDUOp)) begin
            a_d     = mdu.SrcA;
            b_d     = mdu.SrcB;
            op_d    = mdu.MDUOp;
            cnt_d   = ((mdu.MDUOp == OP_DIV) || (mdu.MDUOp == OP_DIVU)) ?
                      32'(DIV_CYCLES) : 32'(MULT_CYCLES);
            state_d = RUN;
          end else if (mdu.MDUOp == OP_MTHI) begin
            hi_d = mdu.SrcA;
          end else if (mdu.MDUOp == OP_MTLO) begin
            lo_d = mdu.SrcA;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV:   if (!b_zero) begin hi_d = r_s; lo_d = q_s; end
            OP_DIVU:  if (!b_zero) begin hi_d = r_u; lo_d = q_u; end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'b111;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mdu.Busy = (state_q == RUN);
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: scoreboard of expected {HI,LO} and Busy length per operation.
module tb_mdu_seq;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_NONE  = 3'b111;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_seq_if bus ();
  mdu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .mdu(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] m_hi, m_lo;

  // All drives happen at a negedge; returns at the following negedge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1; bus.MDUOp = op; bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDUOp = OP_NONE;
  endtask

  task automatic wait_idle(output int cyc, output bit to);
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    to = (cyc >= 200);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int cyc, output bit to);
    drive(op, a, b);
    wait_idle(cyc, to);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb;
    int ia, ib;
    longint unsigned ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    ia = $signed(a); ib = $signed(b);
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return 64'(ua * ub);
      OP_DIV:   if (b == 0) return {hi, lo};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                else return {32'(ia % ib), 32'(ia / ib)};
      OP_DIVU:  if (b == 0) return {hi, lo}; else return {a % b, a / b};
      default:  return {hi, lo};
    endcase
  endfunction

  task automatic test_reset();
    bus.Start = 1'b0; bus.MDUOp = OP_NONE; bus.SrcA = '0; bus.SrcB = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    n_tests++; if (bus.HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.HI); end
    n_tests++; if (bus.LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.LO); end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_mult();
    int cyc, el; bit to; logic [63:0] e;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFE}); lat_q.push_back(MC);
    exp_q.push_back({32'h00000001, 32'hFFFFFFFE}); lat_q.push_back(MC);
    for (int i = 0; i < 2; i++) begin
      run(i == 0 ? OP_MULT : OP_MULTU, 32'hFFFFFFFF, 32'd2, cyc, to);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++; if (to || cyc != el) begin n_fail++; $display("FAIL mult%0d_busy: got %0d cycles want %0d", i, cyc, el); end
      n_tests++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL mult%0d_hilo: got %h want %h", i, {bus.HI, bus.LO}, e); end
      {m_hi, m_lo} = e;
    end
  endtask

  task automatic test_div();
    int cyc, el; bit to; logic [63:0] e;
    logic [2:0]  ops[3] = '{OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as[3]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] bs[3]  = '{32'd2, 32'd0, 32'hFFFFFFFF};
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD}); lat_q.push_back(DC);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD}); lat_q.push_back(DC);
    exp_q.push_back({32'h00000000, 32'h80000000}); lat_q.push_back(DC);
    for (int i = 0; i < 3; i++) begin
      run(ops[i], as[i], bs[i], cyc, to);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++; if (to || cyc != el) begin n_fail++; $display("FAIL div%0d_busy: got %0d cycles want %0d", i, cyc, el); end
      n_tests++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL div%0d_hilo: got %h want %h", i, {bus.HI, bus.LO}, e); end
      {m_hi, m_lo} = e;
    end
  endtask

  task automatic test_mtlo_mthi();
    drive(OP_MTLO, 32'h1234, 32'd0);
    n_tests++; if (bus.LO !== 32'h1234 || bus.Busy !== 1'b0) begin n_fail++; $display("FAIL mtlo: got LO=%h Busy=%b want 1234/0", bus.LO, bus.Busy); end
    n_tests++; if (bus.HI !== m_hi) begin n_fail++; $display("FAIL mtlo_hi: got %h want %h", bus.HI, m_hi); end
    drive(OP_MTHI, 32'hCAFE0001, 32'd0);
    n_tests++; if (bus.HI !== 32'hCAFE0001 || bus.LO !== 32'h1234 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL mthi: got HI=%h LO=%h Busy=%b want cafe0001/1234/0", bus.HI, bus.LO, bus.Busy);
    end
    m_hi = 32'hCAFE0001; m_lo = 32'h1234;
  endtask

  task automatic test_none();
    drive(OP_NONE, 32'h5555, 32'h3);
    bus.MDUOp = OP_MULT; bus.SrcA = 32'h77; bus.SrcB = 32'h2;
    @(negedge clk);
    bus.MDUOp = OP_NONE;
    n_tests++; if (bus.Busy !== 1'b0 || {bus.HI, bus.LO} !== {m_hi, m_lo}) begin
      n_fail++; $display("FAIL none: got Busy=%b HILO=%h want 0/%h", bus.Busy, {bus.HI, bus.LO}, {m_hi, m_lo});
    end
  endtask

  task automatic test_ignore_start();
    int cyc, el; bit to; logic [63:0] e;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFE}); lat_q.push_back(MC);
    drive(OP_MULT, 32'hFFFFFFFF, 32'd2);
    drive(OP_MTHI, 32'hBEEF, 32'd9);
    bus.SrcA = 32'h1; bus.SrcB = 32'h1;
    wait_idle(cyc, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    n_tests++; if (to || cyc + 1 != el) begin n_fail++; $display("FAIL ignore_busy: got %0d cycles want %0d", cyc + 1, el); end
    n_tests++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL ignore_hilo: got %h want %h", {bus.HI, bus.LO}, e); end
    {m_hi, m_lo} = e;
  endtask

  task automatic test_back_to_back();
    int cyc, el; bit to; logic [63:0] e;
    logic [2:0]  op[8];
    logic [31:0] a[8], b[8];
    logic [31:0] sh, sl;
    sh = m_hi; sl = m_lo;
    for (int i = 0; i < 8; i++) begin
      op[i] = 3'($urandom_range(0, 3));
      a[i]  = $urandom;
      b[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      {sh, sl} = model(op[i], a[i], b[i], sh, sl);
      exp_q.push_back({sh, sl});
      lat_q.push_back(op[i] < OP_DIV ? MC : DC);
    end
    for (int i = 0; i < 8; i++) begin
      run(op[i], a[i], b[i], cyc, to);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      n_tests++; if (to || cyc != el) begin n_fail++; $display("FAIL b2b%0d_busy: op=%0d got %0d want %0d", i, op[i], cyc, el); end
      n_tests++; if ({bus.HI, bus.LO} !== e) begin
        n_fail++; $display("FAIL b2b%0d_hilo: op=%0d a=%h b=%h got %h want %h", i, op[i], a[i], b[i], {bus.HI, bus.LO}, e);
      end
    end
    {m_hi, m_lo} = {sh, sl};
  endtask

  task automatic test_reset_mid();
    drive(OP_MTHI, 32'h11, 32'd0);
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    n_tests++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy3: got %b want 1", bus.Busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_clear: got Busy=%b HI=%h LO=%h want 0/0/0", bus.Busy, bus.HI, bus.LO);
    end
    repeat (DC + 5) @(negedge clk);
    n_tests++; if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_late: got Busy=%b HI=%h LO=%h want 0/0/0", bus.Busy, bus.HI, bus.LO);
    end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_madd();
    int cyc, el; bit to; logic [63:0] e;
    drive(OP_MTHI, 32'd0, 32'd0);
    drive(OP_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    exp_q.push_back({32'd1, 32'd0}); lat_q.push_back(MC);
`else
    exp_q.push_back({32'd0, 32'hFFFFFFFF}); lat_q.push_back(0);
`endif
    run(OP_MADD, 32'd1, 32'd1, cyc, to);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    n_tests++; if (to || cyc != el) begin n_fail++; $display("FAIL madd_busy: got %0d want %0d", cyc, el); end
    n_tests++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL madd_hilo: got %h want %h", {bus.HI, bus.LO}, e); end
    {m_hi, m_lo} = e;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mtlo_mthi();
    test_none();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
